// File: rtl/line_refill_pkg.sv
// ---------------------------------------------------------------------------
// line_refill_pkg
// Shared types for the cache line refill controller: AHB-lite burst, transfer
// and size encodings, plus the refill FSM state enum.
// ---------------------------------------------------------------------------
package line_refill_pkg;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_WRAP4  = 3'b010,
        BURST_INCR4  = 3'b011,
        BURST_WRAP8  = 3'b100,
        BURST_INCR8  = 3'b101,
        BURST_WRAP16 = 3'b110,
        BURST_INCR16 = 3'b111
    } burst_types_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_BURST = 3'd2,
        ST_FILL  = 3'd3,
        ST_ERR   = 3'd4
    } refill_state_e;

endpackage

// File: rtl/addr_parser.sv
// ---------------------------------------------------------------------------
// addr_parser
// Splits a line address (byte address with the 16-byte line offset removed)
// into cache tag and cache index.
//   line_addr  in   28      byte address bits [31:4]
//   tag        out  28-IDX_W
//   index      out  IDX_W
// ---------------------------------------------------------------------------
module addr_parser #(
    parameter int IDX_W = 9
) (
    input  logic [27:0]         line_addr,
    output logic [27-IDX_W:0]   tag,
    output logic [IDX_W-1:0]    index
);

    assign tag   = line_addr[27:IDX_W];
    assign index = line_addr[IDX_W-1:0];

endmodule

// File: rtl/line_refill_ctrl_wrap4_addr_gen.sv
// ---------------------------------------------------------------------------
// wrap4_addr_gen
// Beat address for a 4-beat wrapping word burst. The burst starts at the
// critical word and wraps inside the 16-byte line.
//   base  in   28  line address (byte address bits [31:4])
//   off   in   2   word offset of the critical word
//   beat  in   2   beat number 0..3
//   addr  out  32  byte address of the beat
//   slot  out  2   word slot inside the line the beat lands in
// ---------------------------------------------------------------------------
module wrap4_addr_gen (
    input  logic [27:0] base,
    input  logic [1:0]  off,
    input  logic [1:0]  beat,
    output logic [31:0] addr,
    output logic [1:0]  slot
);

    // 2-bit add gives the mod-4 wrap for free
    assign slot = off + beat;
    assign addr = {base, slot, 2'b00};

endmodule

// File: rtl/line_refill_ctrl.sv
// ---------------------------------------------------------------------------
// line_refill_ctrl
// Fetches one 4-word cache line over AHB-lite with a critical-word-first
// WRAP4 read burst. Delivers the critical word early, then the full line.
//   hclk, hrst                      clock, async active-high reset
//   miss_req, miss_addr, miss_ack   refill request / accept pulse
//   busy                            refill in progress
//   crit_valid, crit_data           critical word pulse
//   fill_valid, fill_line,
//   fill_tag, fill_index            completed line pulse
//   fill_err                        refill aborted on bus error
//   haddr..hwrite, hready,
//   hrdata, hresp                   AHB-lite master read port
//
// state  | meaning
// IDLE   | waiting for miss_req
// ADDR   | beat 0 address phase (NONSEQ)
// BURST  | beats 1..3 address phases and outstanding data phases
// FILL   | fill_valid pulse, line complete
// ERR    | fill_err pulse after an error response
// ---------------------------------------------------------------------------
module line_refill_ctrl
    import line_refill_pkg::*;
#(
    parameter  int CACHE_SIZE = 8192,
    parameter  int CACHE_LINE = 128,
    localparam int IDX_W      = $clog2(CACHE_SIZE * 8 / CACHE_LINE),
    localparam int TAG_W      = 32 - IDX_W - 4
) (
    input  logic                  hclk,
    input  logic                  hrst,
    input  logic                  miss_req,
    input  logic [31:0]           miss_addr,
    output logic                  miss_ack,
    output logic                  busy,
    output logic                  crit_valid,
    output logic [31:0]           crit_data,
    output logic                  fill_valid,
    output logic [CACHE_LINE-1:0] fill_line,
    output logic [TAG_W-1:0]      fill_tag,
    output logic [IDX_W-1:0]      fill_index,
    output logic                  fill_err,
    output logic [31:0]           haddr,
    output logic [1:0]            htrans,
    output logic [2:0]            hburst,
    output logic [2:0]            hsize,
    output logic                  hwrite,
    input  logic                  hready,
    input  logic [31:0]           hrdata,
    input  logic                  hresp
);

    refill_state_e         state_q, state_d;
    htrans_e               htrans_q, htrans_d;
    logic [31:0]           haddr_q, haddr_d;
    logic [27:0]           line_addr_q, line_addr_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            addr_beat_q, addr_beat_d;
    logic [1:0]            data_beat_q, data_beat_d;
    logic                  dphase_q, dphase_d;
    logic [CACHE_LINE-1:0] line_q, line_d;
    logic                  crit_valid_q, crit_valid_d;
    logic [31:0]           crit_data_q, crit_data_d;
    logic                  fill_valid_q, fill_valid_d;
    logic                  fill_err_q, fill_err_d;

    logic                  idle;
    logic [27:0]           gen_base;
    logic [1:0]            gen_off;
    logic [1:0]            gen_beat;
    logic [31:0]           next_addr;
    logic [1:0]            unused_next_slot;
    logic [31:0]           unused_data_addr;
    logic [1:0]            data_slot;
    logic                  unused_addr_bits;

    assign idle             = (state_q == ST_IDLE);
    assign unused_addr_bits = ^miss_addr[1:0];

    // In IDLE the generator looks at the incoming request so beat 0 can be
    // registered onto haddr at the accept edge.
    assign gen_base = idle ? miss_addr[31:4] : line_addr_q;
    assign gen_off  = idle ? miss_addr[3:2]  : off_q;
    assign gen_beat = idle ? 2'd0            : addr_beat_q + 2'd1;

    wrap4_addr_gen u_addr_gen (
        .base (gen_base),
        .off  (gen_off),
        .beat (gen_beat),
        .addr (next_addr),
        .slot (unused_next_slot)
    );

    wrap4_addr_gen u_slot_gen (
        .base (line_addr_q),
        .off  (off_q),
        .beat (data_beat_q),
        .addr (unused_data_addr),
        .slot (data_slot)
    );

    addr_parser #(.IDX_W(IDX_W)) u_addr_parser (
        .line_addr (line_addr_q),
        .tag       (fill_tag),
        .index     (fill_index)
    );

    always_comb begin
        state_d      = state_q;
        htrans_d     = htrans_q;
        haddr_d      = haddr_q;
        line_addr_d  = line_addr_q;
        off_d        = off_q;
        addr_beat_d  = addr_beat_q;
        data_beat_d  = data_beat_q;
        dphase_d     = dphase_q;
        line_d       = line_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        fill_valid_d = 1'b0;
        fill_err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (miss_req) begin
                    line_addr_d = miss_addr[31:4];
                    off_d       = miss_addr[3:2];
                    haddr_d     = next_addr;
                    htrans_d    = HTRANS_NONSEQ;
                    addr_beat_d = 2'd0;
                    data_beat_d = 2'd0;
                    dphase_d    = 1'b0;
                    state_d     = ST_ADDR;
                end
            end

            ST_ADDR, ST_BURST: begin
                // First cycle of a two-cycle error response: drop the burst
                if (dphase_q && hresp && !hready) begin
                    htrans_d = HTRANS_IDLE;
                    dphase_d = 1'b0;
                    fill_err_d = 1'b1;
                    state_d  = ST_ERR;
                end else if (hready) begin
                    if (dphase_q) begin
                        line_d[32*int'(data_slot) +: 32] = hrdata;
                        data_beat_d = data_beat_q + 2'd1;
                        if (data_beat_q == 2'd0) begin
                            crit_valid_d = 1'b1;
                            crit_data_d  = hrdata;
                        end
                        if (data_beat_q == 2'd3) begin
                            fill_valid_d = 1'b1;
                            state_d      = ST_FILL;
                        end
                    end
                    if (htrans_q != HTRANS_IDLE) begin
                        dphase_d = 1'b1;
                        if (addr_beat_q == 2'd3) begin
                            htrans_d = HTRANS_IDLE;
                        end else begin
                            addr_beat_d = addr_beat_q + 2'd1;
                            haddr_d     = next_addr;
                            htrans_d    = HTRANS_SEQ;
                        end
                        if (state_q == ST_ADDR) begin
                            state_d = ST_BURST;
                        end
                    end else begin
                        dphase_d = 1'b0;
                    end
                end
            end

            ST_FILL: state_d = ST_IDLE;

            ST_ERR: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_q      <= ST_IDLE;
            htrans_q     <= HTRANS_IDLE;
            haddr_q      <= 32'd0;
            line_addr_q  <= 28'd0;
            off_q        <= 2'd0;
            addr_beat_q  <= 2'd0;
            data_beat_q  <= 2'd0;
            dphase_q     <= 1'b0;
            line_q       <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= 32'd0;
            fill_valid_q <= 1'b0;
            fill_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            htrans_q     <= htrans_d;
            haddr_q      <= haddr_d;
            line_addr_q  <= line_addr_d;
            off_q        <= off_d;
            addr_beat_q  <= addr_beat_d;
            data_beat_q  <= data_beat_d;
            dphase_q     <= dphase_d;
            line_q       <= line_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
            fill_valid_q <= fill_valid_d;
            fill_err_q   <= fill_err_d;
        end
    end

    // Ack is a decode of the current state; gated so nothing is accepted
    // while reset is held.
    assign miss_ack   = idle && miss_req && !hrst;
    assign busy       = !idle;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
    assign fill_valid = fill_valid_q;
    assign fill_line  = line_q;
    assign fill_err   = fill_err_q;
    assign haddr      = haddr_q;
    assign htrans     = htrans_q;
    assign hburst     = BURST_WRAP4;
    assign hsize      = HSIZE_WORD;
    assign hwrite     = 1'b0;

endmodule

// File: tb/tb_line_refill_ctrl.sv
module tb_line_refill_ctrl;

    logic         hclk = 1'b0;
    logic         hrst;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         miss_ack;
    logic         busy;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         fill_valid;
    logic [127:0] fill_line;
    logic [18:0]  fill_tag;
    logic [8:0]   fill_index;
    logic         fill_err;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic [2:0]   hsize;
    logic         hwrite;
    logic         hready;
    logic [31:0]  hrdata;
    logic         hresp;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [127:0] L1008 = 128'hA500100C_A5001008_A5001004_A5001000;
    localparam logic [127:0] L3A34 = 128'hA5003A3C_A5003A38_A5003A34_A5003A30;
    localparam logic [127:0] L0000 = 128'hA500000C_A5000008_A5000004_A5000000;

    line_refill_ctrl dut (
        .hclk       (hclk),
        .hrst       (hrst),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .miss_ack   (miss_ack),
        .busy       (busy),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .fill_valid (fill_valid),
        .fill_line  (fill_line),
        .fill_tag   (fill_tag),
        .fill_index (fill_index),
        .fill_err   (fill_err),
        .haddr      (haddr),
        .htrans     (htrans),
        .hburst     (hburst),
        .hsize      (hsize),
        .hwrite     (hwrite),
        .hready     (hready),
        .hrdata     (hrdata),
        .hresp      (hresp)
    );

    always #5 hclk = ~hclk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    // Slave side: tracks which transfer is in its data phase
    logic        dp_valid;
    logic [31:0] dp_addr;
    int          dbeat;
    bit          err_data = 1'b0;

    always @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            dp_valid <= 1'b0;
            dp_addr  <= 32'd0;
            dbeat    <= 0;
        end else begin
            if (hready) begin
                if (dp_valid) dbeat <= dbeat + 1;
                dp_valid <= htrans[1];
                dp_addr  <= haddr;
            end
            if (miss_ack) dbeat <= 0;
        end
    end

    always_comb begin
        hrdata = 32'hDEAD_BEEF;
        if (dp_valid && !err_data) hrdata = mem(dp_addr);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge hclk);
        #2;
    endtask

    task automatic run_refill(input string tag, input logic [31:0] addr, input bit hold_req,
                              input int wbeat, input int nwait,
                              input logic [31:0] ea0, input logic [31:0] ea1,
                              input logic [31:0] ea2, input logic [31:0] ea3,
                              input int efill, input logic [127:0] eline,
                              input logic [31:0] ecrit, input logic [8:0] eidx,
                              input logic [18:0] etag);
        logic [31:0] ea [4];
        logic [31:0] a_q [$];
        logic [1:0]  t_q [$];
        logic [31:0] crit_seen;
        logic [1:0]  et;
        logic [31:0] ga;
        logic [1:0]  gt;
        int crit_cyc, fill_cyc, err_cnt, wleft;
        ea[0] = ea0; ea[1] = ea1; ea[2] = ea2; ea[3] = ea3;
        crit_cyc = -1; fill_cyc = -1; err_cnt = 0; wleft = nwait;
        crit_seen = 32'd0;

        step();
        miss_req = 1'b1; miss_addr = addr; hready = 1'b1; hresp = 1'b0;
        #1;
        check({tag, "_ack"}, miss_ack, 1'b1);
        check({tag, "_idle_busy"}, busy, 1'b0);

        for (int c = 1; c <= 30 && fill_cyc < 0; c++) begin
            step();
            if (!hold_req) miss_req = 1'b0;
            hready = 1'b1;
            if (dp_valid && dbeat == wbeat && wleft > 0) begin
                hready = 1'b0;
                wleft--;
            end
            #1;
            if (hold_req) check({tag, "_no_ack"}, miss_ack, 1'b0);
            if (c == 1) begin
                check({tag, "_nonseq"}, htrans, 2'b10);
                check({tag, "_busy"}, busy, 1'b1);
                check({tag, "_ctrl"}, {hburst, hsize, hwrite}, {3'b010, 3'b010, 1'b0});
            end
            if (htrans != 2'b00 && !hready && a_q.size() > 0 && a_q.size() < 4) begin
                check({tag, "_hold_addr"}, haddr, ea[a_q.size()]);
                check({tag, "_hold_trans"}, htrans, 2'b11);
            end
            if (htrans != 2'b00 && hready) begin
                a_q.push_back(haddr);
                t_q.push_back(htrans);
            end
            if (crit_valid) begin
                crit_cyc  = c;
                crit_seen = crit_data;
            end
            if (fill_err) err_cnt++;
            if (fill_valid) begin
                fill_cyc = c;
                check({tag, "_line"}, fill_line, eline);
                check({tag, "_index"}, fill_index, eidx);
                check({tag, "_tag"}, fill_tag, etag);
            end
        end

        check({tag, "_fill_cycle"}, fill_cyc, efill);
        check({tag, "_crit_cycle"}, crit_cyc, 3);
        check({tag, "_crit_data"}, crit_seen, ecrit);
        check({tag, "_no_err"}, err_cnt, 0);
        check({tag, "_nbeats"}, a_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            ga = (i < a_q.size()) ? a_q[i] : 32'hFFFF_FFFF;
            gt = (i < t_q.size()) ? t_q[i] : 2'b00;
            et = (i == 0) ? 2'b10 : 2'b11;
            check($sformatf("%s_haddr%0d", tag, i), ga, ea[i]);
            check($sformatf("%s_htrans%0d", tag, i), gt, et);
        end
    endtask

    initial begin
        int errc, fillc;
        hrst = 1'b1; miss_req = 1'b0; miss_addr = 32'd0; hready = 1'b1; hresp = 1'b0;
        #3;
        check("rst_htrans", htrans, 2'b00);
        check("rst_haddr", haddr, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_ctrl", {hburst, hsize, hwrite}, {3'b010, 3'b010, 1'b0});
        check("rst_pulses", {miss_ack, crit_valid, fill_valid, fill_err}, 4'b0000);
        step();
        hrst = 1'b0;

        // zero wait states, critical word at 0x1008
        run_refill("s1", 32'h0000_1008, 1'b0, -1, 0,
                   32'h1008, 32'h100C, 32'h1000, 32'h1004,
                   6, L1008, 32'hA500_1008, 9'h100, 19'h0);

        // two wait states on beat 1
        run_refill("s2", 32'h0000_1008, 1'b0, 1, 2,
                   32'h1008, 32'h100C, 32'h1000, 32'h1004,
                   8, L1008, 32'hA500_1008, 9'h100, 19'h0);

        // error response on beat 2
        errc = 0; fillc = 0;
        step();
        miss_req = 1'b1; miss_addr = 32'h0000_1008; hready = 1'b1; hresp = 1'b0;
        #1;
        check("err_ack", miss_ack, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            step();
            miss_req = 1'b0;
            hready   = (c == 4) ? 1'b0 : 1'b1;
            hresp    = (c == 4 || c == 5);
            err_data = (c == 4 || c == 5);
            #1;
            if (fill_err) errc++;
            if (fill_valid) fillc++;
            if (c == 5) begin
                check("err_htrans_idle", htrans, 2'b00);
                check("err_pulse", fill_err, 1'b1);
            end
            if (c == 6) check("err_busy_after", busy, 1'b0);
        end
        check("err_count", errc, 1);
        check("err_no_fill", fillc, 0);
        check("err_no_capture", fill_line, L1008);

        // miss_req held high throughout, second request taken right after fill
        run_refill("s4a", 32'h0000_1008, 1'b1, -1, 0,
                   32'h1008, 32'h100C, 32'h1000, 32'h1004,
                   6, L1008, 32'hA500_1008, 9'h100, 19'h0);
        run_refill("s4b", 32'h0000_3A34, 1'b0, -1, 0,
                   32'h3A34, 32'h3A38, 32'h3A3C, 32'h3A30,
                   6, L3A34, 32'hA500_3A34, 9'h1A3, 19'h1);

        // reset during beat 1
        errc = 0; fillc = 0;
        step();
        miss_req = 1'b1; miss_addr = 32'h0000_1008; hready = 1'b1; hresp = 1'b0;
        #1;
        check("rst2_ack", miss_ack, 1'b1);
        step();
        miss_req = 1'b0;
        step();
        #1;
        hrst = 1'b1;
        #1;
        check("rst2_htrans", htrans, 2'b00);
        check("rst2_haddr", haddr, 32'd0);
        check("rst2_busy", busy, 1'b0);
        check("rst2_data", {crit_data, fill_tag, fill_index}, 60'd0);
        check("rst2_line", fill_line, 128'd0);
        check("rst2_pulses", {miss_ack, crit_valid, fill_valid, fill_err}, 4'b0000);
        step();
        hrst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (fill_err) errc++;
            if (fill_valid) fillc++;
            step();
        end
        check("rst2_no_fill", fillc, 0);
        check("rst2_no_err", errc, 0);

        run_refill("s5", 32'h0000_0000, 1'b0, -1, 0,
                   32'h0, 32'h4, 32'h8, 32'hC,
                   6, L0000, 32'hA500_0000, 9'h000, 19'h0);

        step();
        #1;
        check("end_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
